fp_addsub_pipe: RTL

- Parametrised IEEE-754-style floating-point adder/subtractor.
- Next generation of the team's single-precision adder, with:
  - configurable exponent and mantissa widths;
  - a 3-stage pipeline with valid/ready backpressure;
  - a per-operation add/sub select;
  - round-to-nearest-even;
  - special-value handling and exception flags.
- Sits in the arithmetic datapath between operand FIFOs and result consumers.
- The default configuration is binary32.

---
 rtl/fp_addsub_pipe.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/fp_addsub_pipe.sv
// Parametrised floating-point adder/subtractor: 3-stage valid/ready pipeline,
// round-to-nearest-even, flush-to-zero, special values and exception flags.
module fp_addsub_pipe #(
    parameter  int EXP_W = 8,
    parameter  int MAN_W = 23,
    localparam int W     = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] c,
    output logic [3:0]   flags
);
    // Working significand: hidden + fraction + guard + round + sticky.
    localparam int F    = MAN_W + 4;
    localparam int LZ_W = $clog2(F + 1);
    localparam int SH_W = $clog2(MAN_W + 4);
    localparam int EW   = EXP_W + 2;
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic signed [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);

    logic en;

    logic             v1_q, spec1_q, sign1_q, effSub1_q;
    logic [W-1:0]     specVal1_q;
    logic [3:0]       specFlg1_q;
    logic [EXP_W-1:0] exp1_q;
    logic [F-1:0]     sigBig1_q, sigSml1_q;

    logic             v2_q, spec2_q, sign2_q;
    logic [W-1:0]     specVal2_q;
    logic [3:0]       specFlg2_q;
    logic [EXP_W-1:0] exp2_q;
    logic [F:0]       sum2_q;
    logic [LZ_W-1:0]  lz2_q;

    logic             v3_q;
    logic [W-1:0]     c_q;
    logic [3:0]       flags_q;

    assign en        = !v3_q || out_ready;
    assign in_ready  = en;
    assign out_valid = v3_q;
    assign c         = c_q;
    assign flags     = flags_q;

    logic             sA, sB, zA, zB, infA, infB, nanA, nanB, aBig, lost;
    logic [EXP_W-1:0] eA, eB, eSml, diffE;
    logic [MAN_W-1:0] fA, fB, fAz, fBz;
    logic [F-1:0]     sigA, sigB, sigSml, shifted;
    logic [SH_W-1:0]  shamt;

    logic             spec1_d, sign1_d;
    logic [W-1:0]     specVal1_d;
    logic [3:0]       specFlg1_d;
    logic [EXP_W-1:0] exp1_d;
    logic [F-1:0]     sigBig1_d, sigSml1_d;

    assign sA   = a[W-1];
    assign sB   = b[W-1] ^ sub;
    assign eA   = a[W-2:MAN_W];
    assign eB   = b[W-2:MAN_W];
    assign fA   = a[MAN_W-1:0];
    assign fB   = b[MAN_W-1:0];
    assign zA   = (eA == '0);
    assign zB   = (eB == '0);
    assign infA = (&eA) && (fA == '0);
    assign infB = (&eB) && (fB == '0);
    assign nanA = (&eA) && (fA != '0);
    assign nanB = (&eB) && (fB != '0);
    assign fAz  = zA ? '0 : fA;
    assign fBz  = zB ? '0 : fB;
    assign aBig = {eA, fAz} >= {eB, fBz};
    assign sigA = {~zA, fAz, 3'b000};
    assign sigB = {~zB, fBz, 3'b000};

    always_comb begin
        if (aBig) begin
            sign1_d   = sA;
            exp1_d    = eA;
            eSml      = eB;
            sigBig1_d = sigA;
            sigSml    = sigB;
        end else begin
            sign1_d   = sB;
            exp1_d    = eB;
            eSml      = eA;
            sigBig1_d = sigB;
            sigSml    = sigA;
        end
        diffE = exp1_d - eSml;
        if (32'(diffE) > 32'(MAN_W + 3)) shamt = SH_W'(MAN_W + 3);
        else                              shamt = SH_W'(diffE);
        shifted   = sigSml >> shamt;
        lost      = (shifted << shamt) != sigSml;
        sigSml1_d = {shifted[F-1:1], shifted[0] | lost};

        // Specials bypass the arithmetic and ride the pipeline as a ready-made result.
        spec1_d    = 1'b1;
        specVal1_d = '0;
        specFlg1_d = '0;
        if (nanA || nanB) begin
            specVal1_d = QNAN;
        end else if (infA && infB && (sA != sB)) begin
            specVal1_d = QNAN;
            specFlg1_d = 4'b1000;
        end else if (infA) begin
            specVal1_d = {sA, a[W-2:0]};
        end else if (infB) begin
            specVal1_d = {sB, b[W-2:0]};
        end else if (zA && zB) begin
            specVal1_d = {sA & sB, {(W-1){1'b0}}};
        end else begin
            spec1_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v1_q       <= 1'b0;
            spec1_q    <= 1'b0;
            sign1_q    <= 1'b0;
            effSub1_q  <= 1'b0;
            specVal1_q <= '0;
            specFlg1_q <= '0;
            exp1_q     <= '0;
            sigBig1_q  <= '0;
            sigSml1_q  <= '0;
        end else if (en) begin
            v1_q       <= in_valid;
            spec1_q    <= spec1_d;
            sign1_q    <= sign1_d;
            effSub1_q  <= sA ^ sB;
            specVal1_q <= specVal1_d;
            specFlg1_q <= specFlg1_d;
            exp1_q     <= exp1_d;
            sigBig1_q  <= sigBig1_d;
            sigSml1_q  <= sigSml1_d;
        end
    end

    function automatic logic [LZ_W-1:0] lzc(input logic [F-1:0] x);
        lzc = LZ_W'(F);
        for (int i = 0; i < F; i++) begin
            if (x[i]) lzc = LZ_W'(F - 1 - i);
        end
    endfunction

    logic [F:0] sum2_d;

    assign sum2_d = effSub1_q ? ({1'b0, sigBig1_q} - {1'b0, sigSml1_q})
                              : ({1'b0, sigBig1_q} + {1'b0, sigSml1_q});

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v2_q       <= 1'b0;
            spec2_q    <= 1'b0;
            sign2_q    <= 1'b0;
            specVal2_q <= '0;
            specFlg2_q <= '0;
            exp2_q     <= '0;
            sum2_q     <= '0;
            lz2_q      <= '0;
        end else if (en) begin
            v2_q       <= v1_q;
            spec2_q    <= spec1_q;
            sign2_q    <= sign1_q;
            specVal2_q <= specVal1_q;
            specFlg2_q <= specFlg1_q;
            exp2_q     <= exp1_q;
            sum2_q     <= sum2_d;
            lz2_q      <= lzc(sum2_d[F-1:0]);
        end
    end

    logic signed [EW-1:0] expBase, lzExt, expN, expR;
    logic [F-1:0]         norm;
    logic [MAN_W+1:0]     rounded;
    logic [MAN_W-1:0]     fracR;
    logic                 inc, inexact;
    logic [W-1:0]         c_d;
    logic [3:0]           flags_d;

    assign expBase = {2'b00, exp2_q};
    assign lzExt   = EW'(lz2_q);

    always_comb begin
        if (sum2_q[F]) begin
            norm = {sum2_q[F:2], sum2_q[1] | sum2_q[0]};
            expN = expBase + EW'(1);
        end else begin
            norm = sum2_q[F-1:0] << lz2_q;
            expN = expBase - lzExt;
        end
        inexact = norm[2] | norm[1] | norm[0];
        inc     = norm[2] & (norm[1] | norm[0] | norm[3]);
        rounded = {1'b0, norm[F-1:3]} + (MAN_W+2)'(inc);
        if (rounded[MAN_W+1]) begin
            fracR = rounded[MAN_W:1];
            expR  = expN + EW'(1);
        end else begin
            fracR = rounded[MAN_W-1:0];
            expR  = expN;
        end

        c_d     = {sign2_q, expR[EXP_W-1:0], fracR};
        flags_d = {3'b000, inexact};
        if (spec2_q) begin
            c_d     = specVal2_q;
            flags_d = specFlg2_q;
        end else if (sum2_q == '0) begin
            c_d     = '0;
            flags_d = '0;
        end else if (expR >= EXP_MAX) begin
            c_d     = {sign2_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flags_d = 4'b0101;
        end else if (expR <= EW'(0)) begin
            c_d     = {sign2_q, {(W-1){1'b0}}};
            flags_d = 4'b0011;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v3_q    <= 1'b0;
            c_q     <= '0;
            flags_q <= '0;
        end else if (en) begin
            v3_q    <= v2_q;
            c_q     <= c_d;
            flags_q <= flags_d;
        end
    end
endmodule
